// File: rtl/dmem_mmio.sv
// dmem_mmio: CPU data-side word RAM, free-running cycle counter and debug TX FIFO, all memory-mapped; rdata is zero-latency combinational.
// Writes commit on the clk edge; a TXDATA push into a full FIFO is dropped and sets ovf; the sink drains via dbg_valid/dbg_ready.

module dmem_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so a full FIFO may still accept a push.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module dmem_mmio #(
  parameter int          RAM_AW     = 11,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] RAM_BASE   = 16'h1001,
  parameter logic [15:0] IO_BASE    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  output logic [31:0] rdata,
  output logic [31:0] dbg_data,
  output logic        dbg_valid,
  input  logic        dbg_ready,
  output logic        bus_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        reg_sel;
  logic              ram_hit;
  logic              io_hit;
  logic              unmapped;
  logic              rd;
  logic              wr;
  logic              tx_wr;
  logic [31:0]       cycle_cnt;
  logic              ovf;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [7:0]        cnt8;
  logic [31:0]       status;
  logic              unused_addr_lsb;

  // Word access only: the byte offset is deliberately ignored.
  assign unused_addr_lsb = ^DM_addr[1:0];

  assign ram_hit  = (DM_addr[31:16] == RAM_BASE);
  assign io_hit   = (DM_addr[31:16] == IO_BASE) && (DM_addr[15:4] == 12'h000);
  assign unmapped = !ram_hit && !io_hit;
  assign ram_idx  = DM_addr[RAM_AW+1:2];
  assign reg_sel  = DM_addr[3:2];
  assign rd       = DM_CS && DM_R;
  assign wr       = DM_CS && DM_W;
  assign tx_wr    = wr && io_hit && (reg_sel == 2'd2);
  assign fifo_pop = dbg_valid && dbg_ready;

  // RAM has no reset path: a store during reset still lands.
  always_ff @(posedge clk) begin
    if (wr && ram_hit) begin
      ram[ram_idx] <= DM_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (wr && io_hit && (reg_sel == 2'd0)) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr && io_hit && (reg_sel == 2'd1)) begin
      ovf <= 1'b0;
    end else if (tx_wr && fifo_full && !fifo_pop) begin
      ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (DM_CS && (DM_R || DM_W) && unmapped) begin
      bus_err <= 1'b1;
    end
  end

  dmem_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .pop   (fifo_pop),
    .wdata (DM_wdata),
    .head  (dbg_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dbg_valid = !fifo_empty;
  assign cnt8      = 8'(fifo_count);
  assign status    = {20'd0, cnt8, 1'b0, ovf, fifo_full, fifo_empty};

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (ram_hit) begin
        rdata = ram[ram_idx];
      end else if (io_hit) begin
        case (reg_sel)
          2'd0:    rdata = cycle_cnt;
          2'd1:    rdata = status;
          default: rdata = '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: stimulus pushes expected read data and debug words into queues; a negedge monitor pops and compares.
module tb_dmem_mmio;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic        DM_CS;
  logic        DM_R;
  logic        DM_W;
  logic [31:0] rdata;
  logic [31:0] dbg_data;
  logic        dbg_valid;
  logic        dbg_ready;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rd[$];
  logic [31:0] exp_dbg[$];

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_TX     = 32'hFFFF_0008;
  localparam logic [31:0] A_RSVD   = 32'hFFFF_000C;

  always #5 clk = ~clk;

  dmem_mmio #(
    .RAM_AW     (11),
    .FIFO_DEPTH (8),
    .RAM_BASE   (16'h1001),
    .IO_BASE    (16'hFFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .DM_addr   (DM_addr),
    .DM_wdata  (DM_wdata),
    .DM_CS     (DM_CS),
    .DM_R      (DM_R),
    .DM_W      (DM_W),
    .rdata     (rdata),
    .dbg_data  (dbg_data),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .bus_err   (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT produced output with no expected value queued", name);
  endtask

  // Monitor: compares every presented read and every valid debug head word.
  always @(negedge clk) begin
    if (DM_CS && DM_R) begin
      if (exp_rd.size() == 0) note_fail("rdata_unexpected");
      else check("rdata", rdata, exp_rd.pop_front());
    end
    if (dbg_valid) begin
      if (exp_dbg.size() == 0) note_fail("dbg_unexpected");
      else begin
        check("dbg_data", dbg_data, exp_dbg[0]);
        if (dbg_ready) void'(exp_dbg.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    DM_CS = 1'b0;
    DM_R  = 1'b0;
    DM_W  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
    DM_addr = a;
    DM_CS   = 1'b1;
    DM_R    = 1'b1;
    DM_W    = 1'b0;
    exp_rd.push_back(e);
    tick();
    idle();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    DM_addr  = a;
    DM_wdata = d;
    DM_CS    = 1'b1;
    DM_R     = 1'b0;
    DM_W     = 1'b1;
    tick();
    idle();
  endtask

  task automatic drain(input string name);
    dbg_ready = 1'b1;
    for (int k = 0; k < 20 && dbg_valid; k++) tick();
    dbg_ready = 1'b0;
    check({name, "_valid_low"}, {31'd0, dbg_valid}, 32'd0);
    check({name, "_all_seen"}, 32'(exp_dbg.size()), 32'd0);
  endtask

  initial begin
    #100000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset     = 1'b1;
    DM_addr   = '0;
    DM_wdata  = '0;
    dbg_ready = 1'b0;
    idle();
    tick();
    tick();
    check("reset_bus_err", {31'd0, bus_err}, 32'd0);
    check("reset_dbg_valid", {31'd0, dbg_valid}, 32'd0);
    check("reset_rdata_idle", rdata, 32'd0);
    reset = 1'b0;

    // Cycle counter: 10 edges after reset, clear-on-write, wrap.
    repeat (10) tick();
    bus_read(A_CYCLE, 32'd10);
    bus_write(A_CYCLE, 32'h1234_5678);
    bus_read(A_CYCLE, 32'd0);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    bus_read(A_CYCLE, 32'hFFFF_FFFF);
    bus_read(A_CYCLE, 32'd0);

    // RAM: word access, byte offset ignored, upper index bits alias.
    bus_write(32'h1001_0014, 32'h1234_5678);
    bus_write(32'h1001_0010, 32'hDEAD_BEEF);
    bus_read(32'h1001_0010, 32'hDEAD_BEEF);
    bus_read(32'h1001_0013, 32'hDEAD_BEEF);
    bus_read(32'h1001_0014, 32'h1234_5678);
    bus_read(32'h1001_2010, 32'hDEAD_BEEF);

    // Read and write in the same cycle shows the old word.
    bus_write(32'h1001_0020, 32'h1);
    DM_addr  = 32'h1001_0020;
    DM_wdata = 32'h2;
    DM_CS    = 1'b1;
    DM_R     = 1'b1;
    DM_W     = 1'b1;
    exp_rd.push_back(32'h1);
    tick();
    idle();
    bus_read(32'h1001_0020, 32'h2);

    DM_addr = 32'h1001_0010;
    DM_R    = 1'b1;
    #1;
    check("cs0_rdata", rdata, 32'd0);
    DM_R = 1'b0;

    // FIFO: fill past full with the sink stalled, then drain.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_dbg.push_back(32'(i));
      bus_write(A_TX, 32'(i));
    end
    bus_read(A_STATUS, 32'h86);
    bus_read(A_TX, 32'd0);
    drain("drain1");
    bus_read(A_STATUS, 32'h5);
    bus_write(A_STATUS, 32'd0);
    bus_read(A_STATUS, 32'h1);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) begin
      exp_dbg.push_back(32'h10 + 32'(i));
      bus_write(A_TX, 32'h10 + 32'(i));
    end
    dbg_ready = 1'b1;
    exp_dbg.push_back(32'h18);
    bus_write(A_TX, 32'h18);
    dbg_ready = 1'b0;
    bus_read(A_STATUS, 32'h82);
    drain("drain2");

    // Reserved register and unmapped access.
    bus_write(A_RSVD, 32'h5);
    bus_read(A_RSVD, 32'd0);
    check("bus_err_clear", {31'd0, bus_err}, 32'd0);
    bus_read(32'h0040_0000, 32'd0);
    check("bus_err_set", {31'd0, bus_err}, 32'd1);
    repeat (3) tick();
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset mid-queue with a coincident RAM store.
    for (int i = 0; i < 3; i++) begin
      exp_dbg.push_back(32'h21 + 32'(i));
      bus_write(A_TX, 32'h21 + 32'(i));
    end
    reset    = 1'b1;
    DM_addr  = 32'h1001_0030;
    DM_wdata = 32'hCAFE_F00D;
    DM_CS    = 1'b1;
    DM_W     = 1'b1;
    tick();
    idle();
    reset = 1'b0;
    exp_dbg.delete();
    check("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    bus_read(A_STATUS, 32'h1);
    bus_read(32'h1001_0010, 32'hDEAD_BEEF);
    bus_read(32'h1001_0030, 32'hCAFE_F00D);

    // MMIO page with nonzero addr[15:4] is unmapped.
    bus_read(32'hFFFF_0010, 32'd0);
    check("io_hole_bus_err", {31'd0, bus_err}, 32'd1);

    tick();
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("dbg_queue_empty", 32'(exp_dbg.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
